// File: rtl/fixed_point_addsub_sequencer.sv
// Request-side initiator for the fixed-point add/sub engine.
// Issues one operation, waits under a watchdog, returns a held response.
module fixed_point_addsub_sequencer #(
  parameter int WIDTH    = 8,
  parameter int TIMEOUT  = 15,
  parameter bit SATURATE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  input  logic             i_req_sub,
  output logic             o_start,
  output logic [WIDTH-1:0] o_operandA,
  output logic [WIDTH-1:0] o_operandB,
  output logic             o_sub,
  input  logic             i_busy,
  input  logic             i_done,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_overflow,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_overflow,
  output logic             o_rsp_error,
  output logic [7:0]       o_ovf_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             sub_q, sub_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             rvld_q, rvld_d;
  logic [WIDTH-1:0] rdat_q, rdat_d;
  logic             rovf_q, rovf_d;
  logic             rerr_q, rerr_d;
  logic [7:0]       ovfc_q, ovfc_d;
  logic [WIDTH-1:0] res_data;

  // Overflow always takes the sign of A, so A's sign picks the clamp.
  always_comb begin
    res_data = i_data;
    if (SATURATE && i_overflow) begin
      res_data = opa_q[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    rvld_d  = rvld_q;
    rdat_d  = rdat_q;
    rovf_d  = rovf_q;
    rerr_d  = rerr_q;
    ovfc_d  = ovfc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          opa_d   = i_req_a;
          opb_d   = i_req_b;
          sub_d   = i_req_sub;
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_done && i_valid) begin
          rvld_d  = 1'b1;
          rdat_d  = res_data;
          rovf_d  = i_overflow;
          rerr_d  = 1'b0;
          if (i_overflow && ovfc_q != 8'hFF) begin
            ovfc_d = ovfc_q + 8'd1;
          end
          state_d = ST_RESP;
        end else if (i_done) begin
          rvld_d  = 1'b1;
          rdat_d  = '0;
          rovf_d  = 1'b0;
          rerr_d  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TMO) begin
            rvld_d  = 1'b1;
            rdat_d  = '0;
            rovf_d  = 1'b0;
            rerr_d  = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rvld_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
      rdat_q  <= '0;
      rovf_q  <= 1'b0;
      rerr_q  <= 1'b0;
      ovfc_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rdat_q  <= rdat_d;
      rovf_q  <= rovf_d;
      rerr_q  <= rerr_d;
      ovfc_q  <= ovfc_d;
    end
  end

  assign o_req_ready    = (state_q == ST_IDLE);
  assign o_start        = start_q;
  assign o_operandA     = opa_q;
  assign o_operandB     = opb_q;
  assign o_sub          = sub_q;
  assign o_rsp_valid    = rvld_q;
  assign o_rsp_data     = rdat_q;
  assign o_rsp_overflow = rovf_q;
  assign o_rsp_error    = rerr_q;
  assign o_ovf_count    = ovfc_q;

  // The engine must be idle whenever a new operation is launched.
  a_start_idle: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) o_start |-> !i_busy
  );

endmodule

// File: tb/tb_fixed_point_addsub_sequencer.sv
// Directed bench for fixed_point_addsub_sequencer.
// Two instances: SATURATE=1 (u0) and SATURATE=0 (u1), shared stimulus.
module tb_fixed_point_addsub_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic       req_sub = 1'b0;
  logic       busy = 1'b0;
  logic       done = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = '0;
  logic       ovf = 1'b0;
  logic       rsp_ready = 1'b0;

  logic       req_ready0, start0, sub0, rvld0, rovf0, rerr0;
  logic [7:0] opa0, opb0, rdat0, ovfc0;
  logic       req_ready1, start1, sub1, rvld1, rovf1, rerr1;
  logic [7:0] opa1, opb1, rdat1, ovfc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fixed_point_addsub_sequencer #(.WIDTH(8), .TIMEOUT(15), .SATURATE(1'b1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready0),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_sub(req_sub),
    .o_start(start0), .o_operandA(opa0), .o_operandB(opb0), .o_sub(sub0),
    .i_busy(busy), .i_done(done), .i_valid(valid),
    .i_data(data), .i_overflow(ovf),
    .o_rsp_valid(rvld0), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rdat0), .o_rsp_overflow(rovf0),
    .o_rsp_error(rerr0), .o_ovf_count(ovfc0)
  );

  fixed_point_addsub_sequencer #(.WIDTH(8), .TIMEOUT(15), .SATURATE(1'b0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready1),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_sub(req_sub),
    .o_start(start1), .o_operandA(opa1), .o_operandB(opb1), .o_sub(sub1),
    .i_busy(busy), .i_done(done), .i_valid(valid),
    .i_data(data), .i_overflow(ovf),
    .o_rsp_valid(rvld1), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rdat1), .o_rsp_overflow(rovf1),
    .o_rsp_error(rerr1), .o_ovf_count(ovfc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE: handshake, then advance into WAIT cycle 1.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic s);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_sub = s;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic finish_eng(input logic v, input logic [7:0] d,
                            input logic o);
    done = 1'b1;
    valid = v;
    data = d;
    ovf = o;
    tick();
    done = 1'b0;
    valid = 1'b0;
    ovf = 1'b0;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [7:0] held;

  initial begin
    #2;
    chk("rst_ready", req_ready0, 1);
    chk("rst_start", start0, 0);
    chk("rst_opa", opa0, 0);
    chk("rst_rvld", rvld0, 0);
    chk("rst_rdat", rdat0, 0);
    chk("rst_err", rerr0, 0);
    chk("rst_cnt", ovfc0, 0);
    #10 rst_n = 1'b1;
    tick();

    // Basic add 0x12+0x05
    req_valid = 1'b1;
    req_a = 8'h12;
    req_b = 8'h05;
    req_sub = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("t1_start_hi", start0, 1);
    chk("t1_ready_issue", req_ready0, 0);
    chk("t1_opa", opa0, 8'h12);
    chk("t1_opb", opb0, 8'h05);
    tick();
    chk("t1_start_lo", start0, 0);
    chk("t1_ready_wait", req_ready0, 0);
    tick();
    chk("t1_start_lo2", start0, 0);
    finish_eng(1'b1, 8'h17, 1'b0);
    chk("t1_rvld", rvld0, 1);
    chk("t1_rdat", rdat0, 8'h17);
    chk("t1_ovf", rovf0, 0);
    chk("t1_err", rerr0, 0);
    chk("t1_ready_resp", req_ready0, 0);
    chk("t1_opa_hold", opa0, 8'h12);
    ack();
    chk("t1_rvld_lo", rvld0, 0);
    chk("t1_ready_back", req_ready0, 1);

    // Positive saturation
    issue(8'h70, 8'h20, 1'b0);
    tick();
    finish_eng(1'b1, 8'h90, 1'b1);
    chk("sat_rdat", rdat0, 8'h7F);
    chk("sat_ovf", rovf0, 1);
    chk("sat_cnt", ovfc0, 1);
    chk("nosat_rdat", rdat1, 8'h90);
    chk("nosat_ovf", rovf1, 1);
    ack();

    // Negative saturation
    issue(8'h80, 8'h01, 1'b1);
    chk("neg_sub", sub0, 1);
    finish_eng(1'b1, 8'h7F, 1'b1);
    chk("neg_rdat", rdat0, 8'h80);
    chk("neg_cnt", ovfc0, 2);
    chk("neg_nosat", rdat1, 8'h7F);
    ack();

    // Watchdog: no done for 15 WAIT cycles
    issue(8'h01, 8'h02, 1'b0);
    repeat (14) tick();
    chk("wd_not_yet", rvld0, 0);
    tick();
    chk("wd_rvld", rvld0, 1);
    chk("wd_err", rerr0, 1);
    chk("wd_rdat", rdat0, 0);
    chk("wd_ovf", rovf0, 0);
    ack();

    // Done on the timeout cycle is success
    issue(8'h11, 8'h22, 1'b0);
    repeat (14) tick();
    chk("tmo_not_yet", rvld0, 0);
    finish_eng(1'b1, 8'h33, 1'b0);
    chk("tmo_rvld", rvld0, 1);
    chk("tmo_err", rerr0, 0);
    chk("tmo_rdat", rdat0, 8'h33);
    ack();

    // Done without valid
    issue(8'h05, 8'h05, 1'b0);
    finish_eng(1'b0, 8'h55, 1'b1);
    chk("dnv_rvld", rvld0, 1);
    chk("dnv_err", rerr0, 1);
    chk("dnv_rdat", rdat0, 0);
    chk("dnv_ovf", rovf0, 0);
    chk("dnv_cnt", ovfc0, 2);
    ack();

    // Backpressure with a pending request
    issue(8'h40, 8'h01, 1'b1);
    finish_eng(1'b1, 8'h3F, 1'b0);
    held = rdat0;
    chk("bp_first", held, 8'h3F);
    req_valid = 1'b1;
    req_a = 8'h21;
    req_b = 8'h03;
    req_sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rvld", rvld0, 1);
      chk("bp_rdat", rdat0, 8'h3F);
      chk("bp_ready", req_ready0, 0);
      chk("bp_opa", opa0, 8'h40);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rvld_lo", rvld0, 0);
    chk("bp_ready_hi", req_ready0, 1);
    chk("bp_no_start", start0, 0);
    tick();
    req_valid = 1'b0;
    chk("bp_start", start0, 1);
    chk("bp_opa_new", opa0, 8'h21);
    tick();

    // Asynchronous reset during WAIT
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ready", req_ready0, 1);
    chk("ar_opa", opa0, 0);
    chk("ar_rvld", rvld0, 0);
    chk("ar_rdat", rdat0, 0);
    chk("ar_cnt", ovfc0, 0);
    chk("ar_start", start0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ar_ready_after", req_ready0, 1);
    chk("ar_rvld_after", rvld0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
